// File: rtl/z80_snd_pkg.sv
// Shared types and constants for the sound-CPU command port.
package z80_snd_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_PEND = 2'd1,
    IRQ_SERV = 2'd2
  } irq_state_e;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 7;

  localparam logic [7:0] DEF_CMD_PORT  = 8'h00;
  localparam logic [7:0] DEF_STAT_PORT = 8'h01;

  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/z80_snd_fifo.sv
// Command FIFO; a pop frees a full slot for a push in the same clk.
module z80_snd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/z80_snd_cmd_port.sv
// Sound-CPU command port: host FIFO, I/O decode,
// command-read wait states and interrupt request FSM.
module z80_snd_cmd_port
  import z80_snd_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter logic [7:0]  CMD_PORT    = DEF_CMD_PORT,
  parameter logic [7:0]  STAT_PORT   = DEF_STAT_PORT,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic                   host_wr,
  input  logic [7:0]             host_data,
  input  logic [15:0]            adr,
  input  logic                   ix,
  input  logic                   mx,
  input  logic                   rd,
  input  logic                   wr,
  input  logic                   intack,
  output logic [7:0]             data_out,
  output logic                   data_oe,
  output logic                   intreq,
  output logic                   wait_n,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned WCW = $clog2(WAIT_CYCLES + 2);
  localparam bit          WAIT_EN = (WAIT_CYCLES != 0);

  logic           cmd_sel, stat_sel;
  logic           cmd_sel_q, stat_sel_q, intack_q;
  logic           cmd_rise, cmd_fall, stat_fall, ack;
  logic           push, pop, drop, pop_empties;
  logic           ovf_q, ovf_d;
  logic           wait_n_q;
  logic [WCW-1:0] wcnt_q;
  irq_state_e     irq_q;
  logic           intreq_q;
  logic [7:0]     head, status;
  logic           full, empty;
  logic [CW-1:0]  count;
  logic           unused_ok;

  assign unused_ok = ^{mx, adr[15:8]};

  assign cmd_sel  = ix & rd & ~wr & (adr[7:0] == CMD_PORT);
  assign stat_sel = ix & rd & ~wr & (adr[7:0] == STAT_PORT);
  assign data_oe  = cmd_sel | stat_sel;

  assign cmd_rise  = cmd_sel & ~cmd_sel_q;
  assign cmd_fall  = cmd_sel_q & ~cmd_sel;
  assign stat_fall = stat_sel_q & ~stat_sel;
  assign ack       = intack & ~intack_q;

  assign pop  = cmd_fall & ~empty;
  assign push = host_wr & (~full | pop);
  assign drop = host_wr & full & ~pop;

  // Pop that leaves nothing behind (a push in the same clk refills it)
  assign pop_empties = pop & ~push & (count == CW'(1));

  assign ovf_d = drop | (ovf_q & ~stat_fall);

  z80_snd_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (host_data),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    status           = 8'h00;
    status[ST_OVF]   = ovf_q;
    status[ST_FULL]  = full;
    status[ST_AVAIL] = ~empty;
  end

  always_comb begin
    data_out = 8'hFF;
    unique case (1'b1)
      cmd_sel:  data_out = empty ? 8'hFF : head;
      stat_sel: data_out = status;
      default:  data_out = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_sel_q  <= 1'b0;
      stat_sel_q <= 1'b0;
      intack_q   <= 1'b0;
      ovf_q      <= 1'b0;
      wait_n_q   <= 1'b1;
      wcnt_q     <= '0;
      irq_q      <= IRQ_IDLE;
      intreq_q   <= 1'b0;
    end else begin
      cmd_sel_q  <= cmd_sel;
      stat_sel_q <= stat_sel;
      intack_q   <= intack;
      ovf_q      <= ovf_d;

      if (cmd_rise && WAIT_EN) begin
        wait_n_q <= 1'b0;
        wcnt_q   <= WCW'(WAIT_CYCLES);
      end else if (!wait_n_q) begin
        if (!cmd_sel) begin
          wait_n_q <= 1'b1;
          wcnt_q   <= '0;
        end else if (wcnt_q == '0) begin
          wait_n_q <= 1'b1;
        end else if (clk_en) begin
          wcnt_q <= wcnt_q - WCW'(1);
        end
      end

      unique case (irq_q)
        IRQ_IDLE: begin
          if (!empty && !pop_empties) begin
            irq_q    <= IRQ_PEND;
            intreq_q <= 1'b1;
          end
        end
        IRQ_PEND: begin
          if (pop_empties) begin
            irq_q    <= IRQ_IDLE;
            intreq_q <= 1'b0;
          end else if (ack) begin
            irq_q    <= IRQ_SERV;
            intreq_q <= 1'b0;
          end
        end
        IRQ_SERV: begin
          if (pop_empties) begin
            irq_q    <= IRQ_IDLE;
            intreq_q <= 1'b0;
          end else if (pop) begin
            irq_q    <= IRQ_PEND;
            intreq_q <= 1'b1;
          end
        end
        default: begin
          irq_q    <= IRQ_IDLE;
          intreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign wait_n     = wait_n_q;
  assign intreq     = intreq_q;
  assign overflow   = ovf_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_z80_snd_cmd_port.sv
// Bench for z80_snd_cmd_port: queue-based reference model,
// randomized bytes, clk_en patterns and host/CPU traffic.
module tb_z80_snd_cmd_port;

  localparam int DEPTH = 4;
  localparam int WAITC = 2;
  localparam logic [7:0] CMD  = 8'h00;
  localparam logic [7:0] STAT = 8'h01;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        host_wr;
  logic [7:0]  host_data;
  logic [15:0] adr;
  logic        ix, mx, rd, wr, intack;
  logic [7:0]  data_out;
  logic        data_oe, intreq, wait_n, overflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ovf;

  always #5 clk = ~clk;

  z80_snd_cmd_port dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .host_wr    (host_wr),
    .host_data  (host_data),
    .adr        (adr),
    .ix         (ix),
    .mx         (mx),
    .rd         (rd),
    .wr         (wr),
    .intack     (intack),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .intreq     (intreq),
    .wait_n     (wait_n),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  function automatic logic [7:0] exp_status();
    return {m_ovf, 5'b0, q.size() == DEPTH, q.size() != 0};
  endfunction

  // Drives one bus read; hw/hd are applied in the clk the strobe drops.
  // exp_low: clks until the WAITC-th clk_en tick after the rise, plus one.
  task automatic cpu_read(input logic [7:0] port, input bit rnd,
                          input logic hw, input logic [7:0] hd,
                          output logic [7:0] d, output int low,
                          output int exp_low);
    int  ticks;
    logic en;
    ticks = 0;
    low = 0;
    exp_low = (port == CMD) ? -1 : 0;
    @(negedge clk);
    adr = {8'($urandom), port};
    ix = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    d = data_out;
    for (int c = 0; c < 30; c++) begin
      if (wait_n) break;
      low++;
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      clk_en = en;
      if (en) begin
        ticks++;
        if (ticks == WAITC && exp_low < 0) exp_low = c + 2;
      end
      @(negedge clk);
    end
    clk_en = 1'b1;
    rd = 1'b0;
    ix = 1'b0;
    host_wr = hw;
    host_data = hd;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    host_wr = 1'b1;
    host_data = b;
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL rst_intreq got %b exp 0", intreq); end
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_n got %b exp 1", wait_n); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", data_oe); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL rst_data got %h exp ff", data_out); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    reset_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [7:0] d;
    int low, el;
    host_push(b);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_cnt1 got %0d exp 1", fifo_count); end
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL single_irq_early got %b exp 0", intreq); end
    @(negedge clk);
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL single_irq got %b exp 1", intreq); end
    cpu_read(CMD, 1'b0, 1'b0, 8'h00, d, low, el);
    checks++; if (d !== q[0]) begin errors++; $display("FAIL single_data got %h exp %h", d, q[0]); end
    void'(q.pop_front());
    checks++; if (low != el) begin errors++; $display("FAIL single_wait got %0d exp %0d", low, el); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", fifo_count); end
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL single_irq_clr got %b exp 0", intreq); end
  endtask

  task automatic test_overflow();
    logic [7:0] d, e;
    int low, el;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      host_wr = 1'b1;
      host_data = 8'(i);
      if (q.size() < DEPTH) q.push_back(8'(i));
      else m_ovf = 1'b1;
    end
    @(negedge clk);
    host_wr = 1'b0;
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_set got %b exp %b", overflow, m_ovf); end
    checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL ovf_cnt got %0d exp %0d", fifo_count, q.size()); end
    e = exp_status();
    cpu_read(STAT, 1'b0, 1'b0, 8'h00, d, low, el);
    m_ovf = 1'b0;
    checks++; if (d !== e) begin errors++; $display("FAIL ovf_stat got %h exp %h", d, e); end
    checks++; if (low != el) begin errors++; $display("FAIL stat_wait got %0d exp %0d", low, el); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d, b;
    int low, el;
    b = 8'($urandom);
    cpu_read(CMD, 1'b1, 1'b1, b, d, low, el);
    checks++; if (d !== q[0]) begin errors++; $display("FAIL pp_data got %h exp %h", d, q[0]); end
    void'(q.pop_front());
    q.push_back(b);
    checks++; if (low != el) begin errors++; $display("FAIL pp_wait got %0d exp %0d", low, el); end
    checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL pp_cnt got %0d exp %0d", fifo_count, q.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_random();
    logic [7:0] d, e;
    int low, el, op;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op < 2) begin
        host_push(8'($urandom));
      end else if (op == 2) begin
        e = (q.size() != 0) ? q[0] : 8'hFF;
        cpu_read(CMD, 1'b1, 1'b0, 8'h00, d, low, el);
        if (q.size() != 0) void'(q.pop_front());
        checks++; if (d !== e) begin errors++; $display("FAIL rnd_data got %h exp %h", d, e); end
        checks++; if (low != el) begin errors++; $display("FAIL rnd_wait got %0d exp %0d", low, el); end
      end else begin
        e = exp_status();
        cpu_read(STAT, 1'b0, 1'b0, 8'h00, d, low, el);
        m_ovf = 1'b0;
        checks++; if (d !== e) begin errors++; $display("FAIL rnd_stat got %h exp %h", d, e); end
      end
      checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_cnt got %0d exp %0d", fifo_count, q.size()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf got %b exp %b", overflow, m_ovf); end
    end
    while (q.size() != 0) begin
      e = q.pop_front();
      cpu_read(CMD, 1'b0, 1'b0, 8'h00, d, low, el);
      checks++; if (d !== e) begin errors++; $display("FAIL drain_data got %h exp %h", d, e); end
    end
    if (m_ovf) begin
      cpu_read(STAT, 1'b0, 1'b0, 8'h00, d, low, el);
      m_ovf = 1'b0;
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL drain_cnt got %0d exp 0", fifo_count); end
  endtask

  task automatic test_irq();
    logic [7:0] d, e;
    int low, el;
    logic exp_irq;
    host_push(8'($urandom));
    host_push(8'($urandom));
    @(negedge clk);
    checks++; if (intreq !== 1'b1) begin errors++; $display("FAIL irq_pend got %b exp 1", intreq); end
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || intreq) begin
        @(negedge clk); intack = 1'b1;
        @(negedge clk); intack = 1'b0;
        checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL irq_ack got %b exp 0", intreq); end
      end
      if (k == 0) begin
        host_push(8'($urandom));
        @(negedge clk);
        checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL irq_serv_push got %b exp 0", intreq); end
      end
      if (q.size() == 0) break;
      e = q.pop_front();
      cpu_read(CMD, 1'b0, 1'b0, 8'h00, d, low, el);
      exp_irq = (q.size() != 0);
      checks++; if (d !== e) begin errors++; $display("FAIL irq_data got %h exp %h", d, e); end
      checks++; if (intreq !== exp_irq) begin errors++; $display("FAIL irq_after_read got %b exp %b", intreq, exp_irq); end
    end
    repeat (2) @(negedge clk);
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", intreq); end
  endtask

  task automatic test_empty_read();
    logic [7:0] d;
    int low, el;
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL idle_oe got %b exp 0", data_oe); end
    cpu_read(CMD, 1'b1, 1'b0, 8'h00, d, low, el);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL empty_data got %h exp ff", d); end
    checks++; if (low != el) begin errors++; $display("FAIL empty_wait got %0d exp %0d", low, el); end
    repeat (2) @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL empty_cnt got %0d exp 0", fifo_count); end
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL empty_irq got %b exp 0", intreq); end
    test_single(8'($urandom));
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) host_push(8'($urandom));
    @(negedge clk);
    adr = {8'h00, CMD};
    ix = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL mid_wait got %b exp 0", wait_n); end
    checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL mid_oe got %b exp 1", data_oe); end
    reset_n = 1'b0;
    #1;
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL arst_wait got %b exp 1", wait_n); end
    checks++; if (intreq !== 1'b0) begin errors++; $display("FAIL arst_irq got %b exp 0", intreq); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", fifo_count); end
    rd = 1'b0;
    ix = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    test_single(8'h5A);
  endtask

  initial begin
    reset_n = 1'b0;
    clk_en = 1'b1;
    host_wr = 1'b0;
    host_data = 8'h00;
    adr = 16'h0000;
    ix = 1'b0;
    mx = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    intack = 1'b0;
    m_ovf = 1'b0;
    test_reset();
    test_single(8'h5A);
    test_overflow();
    test_push_pop_full();
    test_random();
    test_irq();
    test_empty_read();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
